// File: rtl/mips_host_pkg.sv
// rtl/mips_host_pkg.sv - opcodes, FSM encoding and word geometry for the host bridge
package mips_host_pkg;

  localparam logic [7:0] OP_CLR     = 8'h00;
  localparam logic [7:0] OP_WR_IMEM = 8'h01;
  localparam logic [7:0] OP_WR_DMEM = 8'h02;
  localparam logic [7:0] OP_RD_DMEM = 8'h03;
  localparam logic [7:0] OP_RD_REG  = 8'h04;
  localparam logic [7:0] OP_RUN     = 8'h05;
  localparam logic [7:0] OP_HALT    = 8'h06;

  localparam int WORD_BYTES = 4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_WDATA    = 3'd2,
    ST_WRITE    = 3'd3,
    ST_RD_ISSUE = 3'd4,
    ST_RD_WAIT  = 3'd5,
    ST_RD_OUT   = 3'd6
  } state_t;

endpackage

// File: rtl/mips_host_bridge_hs.sv
// rtl/mips_host_bridge_hs.sv - 4-phase req/ack edge logic producing one strobe per host byte
module host_hs_sync (
  input  logic clk,
  input  logic rst,
  input  logic req_i,
  output logic ack_o,
  output logic byte_stb
);

  logic req_q;

  // A byte is taken only on a fresh request rise while no acknowledge is outstanding.
  assign byte_stb = req_i & ~req_q & ~ack_o;

  // Remember the last request level; raise ack after a strobe, drop it once req is seen low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q <= 1'b0;
      ack_o <= 1'b0;
    end else begin
      req_q <= req_i;
      if (byte_stb) begin
        ack_o <= 1'b1;
      end else if (!req_i) begin
        ack_o <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mips_host_bridge.sv
// rtl/mips_host_bridge.sv - host byte-link responder loading/reading MIPS32 memories and owning run/halt
module mips_host_bridge
  import mips_host_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        ui_in,
  input  logic              req_i,
  output logic              ack_o,
  output logic [7:0]        uo_out,
  output logic              dvalid_o,
  output logic              err_o,
  output logic              core_run_o,
  output logic              mem_we_o,
  output logic              mem_sel_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic              rd_en_o,
  output logic              rd_reg_o,
  input  logic [31:0]       rdata_i
);

  localparam logic [1:0] LAST_BYTE = 2'(WORD_BYTES - 1);
  localparam logic [1:0] LAT       = 2'(RD_LAT);

  state_t      state;
  logic        byte_stb;
  logic        is_write;
  logic        is_reg;
  logic [1:0]  byte_cnt;
  logic [1:0]  lat_cnt;
  logic [31:0] rd_shift;

  host_hs_sync u_hs (
    .clk      (clk),
    .rst      (rst),
    .req_i    (req_i),
    .ack_o    (ack_o),
    .byte_stb (byte_stb)
  );

  // Readback byte is the top of the shift register, forced to zero when nothing is pending.
  assign uo_out = dvalid_o ? rd_shift[31:24] : 8'h00;

  // Command FSM: opcode decode, address/data assembly, read issue/capture and byte readout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      is_write    <= 1'b0;
      is_reg      <= 1'b0;
      byte_cnt    <= 2'd0;
      lat_cnt     <= 2'd0;
      rd_shift    <= 32'h0;
      dvalid_o    <= 1'b0;
      err_o       <= 1'b0;
      core_run_o  <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_sel_o   <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= 32'h0;
      rd_en_o     <= 1'b0;
      rd_reg_o    <= 1'b0;
    end else begin
      mem_we_o <= 1'b0;
      rd_en_o  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (byte_stb) begin
            if (ui_in == OP_CLR) begin
              err_o <= 1'b0;
            end else if (ui_in == OP_RUN) begin
              core_run_o <= 1'b1;
            end else if (ui_in == OP_HALT) begin
              core_run_o <= 1'b0;
            end else if (ui_in > OP_HALT || core_run_o) begin
              // unknown opcode, or memory access attempted while the core owns the memories
              err_o <= 1'b1;
            end else begin
              is_write  <= (ui_in == OP_WR_IMEM) || (ui_in == OP_WR_DMEM);
              is_reg    <= (ui_in == OP_RD_REG);
              mem_sel_o <= (ui_in != OP_WR_IMEM);
              state     <= ST_ADDR;
            end
          end
        end
        ST_ADDR: begin
          if (byte_stb) begin
            mem_addr_o <= ui_in[ADDR_W-1:0];
            byte_cnt   <= 2'd0;
            if (is_write) begin
              state <= ST_WDATA;
            end else begin
              rd_en_o  <= 1'b1;
              rd_reg_o <= is_reg;
              state    <= ST_RD_ISSUE;
            end
          end
        end
        ST_WDATA: begin
          if (byte_stb) begin
            mem_wdata_o <= {mem_wdata_o[23:0], ui_in};
            byte_cnt    <= byte_cnt + 2'd1;
            if (byte_cnt == LAST_BYTE) begin
              mem_we_o <= 1'b1;
              state    <= ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          if (byte_stb) err_o <= 1'b1;
          state <= ST_IDLE;
        end
        ST_RD_ISSUE: begin
          if (byte_stb) err_o <= 1'b1;
          lat_cnt <= 2'd1;
          state   <= ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          if (byte_stb) err_o <= 1'b1;
          if (lat_cnt == LAT) begin
            rd_shift <= rdata_i;
            dvalid_o <= 1'b1;
            byte_cnt <= 2'd0;
            state    <= ST_RD_OUT;
          end else begin
            lat_cnt <= lat_cnt + 2'd1;
          end
        end
        ST_RD_OUT: begin
          if (byte_stb) begin
            rd_shift <= {rd_shift[23:0], 8'h00};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == LAST_BYTE) begin
              dvalid_o <= 1'b0;
              state    <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mips_host_bridge.md
Name: mips_host_bridge

Overview:
- Chip-side responder for the byte-wide host link on the TinyTapeout pins. The host (the bench or an external MCU) is the initiator and drives `ui_in` with a request/acknowledge handshake.
- The bridge decodes commands, assembles 32-bit words and writes them into the MIPS32 core's instruction or data memory. It also reads data memory or the register file back and returns bytes on `uo_out`.
- It owns the core's run/halt control. The top-level wrapper maps `req_i` to `uio_in[0]`, and `ack_o`/`dvalid_o`/`err_o` to `uio_out[1:3]`.

Parameters:
- ADDR_W, 8, memory word-address width (1..8); the address byte is truncated to `ADDR_W` bits.
- RD_LAT, 1, core read latency in cycles from `rd_en` to a valid `rdata_i` (1..3).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- ui_in  in  8  host data byte, sampled on a byte strobe
- req_i  in  1  host request (4-phase handshake)
- ack_o  out  1  bridge acknowledge
- uo_out  out  8  readback byte
- dvalid_o  out  1  `uo_out` holds a valid readback byte
- err_o  out  1  sticky protocol error
- core_run_o  out  1  core enable (1 = running)
- mem_we_o  out  1  one-cycle write strobe
- mem_sel_o  out  1  0 = IMEM, 1 = DMEM
- mem_addr_o  out  ADDR_W  word address
- mem_wdata_o  out  32  write data
- rd_en_o  out  1  one-cycle read strobe
- rd_reg_o  out  1  read targets the register file (uses `mem_addr_o[4:0]`); otherwise DMEM
- rdata_i  in  32  read data, valid `RD_LAT` cycles after `rd_en_o`

Behaviour:
- Reset: every output is 0. FSM is in IDLE, `req_q` = 0, byte counter = 0, shift registers = 0. Reset mid-command discards the partial word; no write is issued.
- Handshake:
  - `byte_stb = req_i & ~req_q & ~ack_o`, where `req_q` is `req_i` registered.
  - `ack_o` rises on the edge after `byte_stb`.
  - `ack_o` falls on the first edge where `req_i` is sampled 0.
  - Rising edges of `req_i` while `ack_o` = 1 are ignored.
  - Minimum of 4 cycles per byte.
- Opcodes:
  - 0x00 CLR: clears `err_o`.
  - 0x01 WR_IMEM, 0x02 WR_DMEM: followed by 1 address byte and 4 data bytes, MSB first.
  - 0x03 RD_DMEM, 0x04 RD_REG: followed by 1 address byte.
  - 0x05 RUN: sets `core_run_o` = 1.
  - 0x06 HALT: sets `core_run_o` = 0.
- FSM states: IDLE, ADDR, WDATA, WRITE, RD_ISSUE, RD_WAIT, RD_OUT.
- IDLE, on `byte_stb`:
  - Opcodes 0x00, 0x05, 0x06 execute in place.
  - Opcodes 0x01..0x04 with `core_run_o` = 0 go to ADDR.
  - Opcodes 0x01..0x04 with `core_run_o` = 1 set `err_o` and stay in IDLE; subsequent bytes are then parsed as new opcodes.
  - Any opcode > 0x06 sets `err_o` and stays in IDLE.
- ADDR: latch `mem_addr_o`. Go to WDATA (counter = 0) for writes, or RD_ISSUE for reads.
- WDATA: each `byte_stb` shifts the byte into `mem_wdata_o` from the LSB side, so byte 0 ends up in [31:24]. After the 4th byte, go to WRITE.
- WRITE: `mem_we_o` = 1 for exactly one cycle, on the cycle after the 4th byte strobe. `mem_sel_o` holds for the whole command. Return to IDLE.
- RD_ISSUE: `rd_en_o` = 1 for one cycle; `rd_reg_o` is set per opcode. Go to RD_WAIT.
- RD_WAIT: count `RD_LAT` cycles, then capture `rdata_i` into the read shift register. Set `dvalid_o` = 1 and go to RD_OUT.
- RD_OUT:
  - `uo_out` = shift register [31:24].
  - Each `byte_stb` (`ui_in` ignored) shifts left by 8.
  - The 4th strobe clears `dvalid_o` and returns to IDLE.
  - `uo_out` = 0 whenever `dvalid_o` = 0.
- If `byte_stb` occurs in WRITE, RD_ISSUE or RD_WAIT, the byte is dropped, `err_o` is set, and the FSM continues.
- `err_o` clears only on CLR or reset.
- RUN/HALT act only from IDLE; mid-command the byte is data.

Decomposition:
- Package `mips_host_pkg`: opcode localparams (OP_CLR..OP_HALT), FSM state enum encoding, `WORD_BYTES` = 4.
- One natural sub-module, `host_hs_sync`: the `req_q`/`ack_o` handshake edge logic producing `byte_stb`. Everything else lives in a single FSM.

Test Plan:
- Reset during WDATA after 2 bytes (0x01, 0x10, 0xAA, 0xBB) -> all outputs 0 and no `mem_we_o`. A following full WR_IMEM writes correctly.
- Bytes 0x01, 0x10, 0xDE, 0xAD, 0xBE, 0xEF -> one `mem_we_o` pulse with `mem_sel_o` = 0, addr 0x10, wdata 0xDEADBEEF, one cycle after the last strobe. `ack_o` follows the 4-phase timing on every byte.
- 0x03, 0x05 with `RD_LAT` = 1 and `rdata_i` = 0x12345678 -> `rd_en_o` pulse with `rd_reg_o` = 0. Then `dvalid_o` = 1 with `uo_out` = 0x12, then 0x34, 0x56, 0x78 on successive strobes, then `dvalid_o` = 0.
- 0x05 then 0x02 -> `core_run_o` = 1, `err_o` = 1, no write. Then 0x06, 0x00 -> `core_run_o` = 0, `err_o` = 0.
- Opcode 0x7F -> `err_o` = 1 and FSM in IDLE. A second `req_i` rise while `ack_o` is high is not acknowledged twice.
- 0x04, 0x1F with `RD_LAT` = 3 -> `rd_reg_o` = 1, `mem_addr_o[4:0]` = 0x1F, and capture exactly 3 cycles after `rd_en_o`.
